// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer for the E stage: single-cycle multiply,
// 32-step restoring divide, pipeline stall while busy, registered HI/LO result.
module muldiv_ctrl #(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flushE,
  input  logic        holdE,
  input  logic        startE,
  input  logic [1:0]  opE,
  input  logic [31:0] srcaE,
  input  logic [31:0] srcbE,
  output logic        stallE,
  output logic        result_valid,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  localparam int CW = $clog2(DIV_ITERS);

  typedef enum logic [1:0] {IDLE, DIV_RUN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   quo, rem, dvs, dz_hi;
  logic          neg_q, neg_r, dz;

  logic          sgn;
  logic [63:0]   prod;
  logic [31:0]   a_mag, b_mag;
  logic [32:0]   rs, diff;
  logic [31:0]   q_next, r_next;

  // Sign-extending to 64 bits lets one truncated multiply cover MULT and MULTU.
  always_comb begin
    sgn   = ~opE[0];
    prod  = {{32{sgn & srcaE[31]}}, srcaE} * {{32{sgn & srcbE[31]}}, srcbE};
    a_mag = (sgn & srcaE[31]) ? -srcaE : srcaE;
    b_mag = (sgn & srcbE[31]) ? -srcbE : srcbE;
    rs     = {rem, quo[31]};
    diff   = rs - {1'b0, dvs};
    q_next = {quo[30:0], ~diff[32]};
    r_next = diff[32] ? rs[31:0] : diff[31:0];
  end

  assign stallE = (state == IDLE && startE && !flushE) || state == DIV_RUN;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      result_valid <= 1'b0;
      hi_o         <= '0;
      lo_o         <= '0;
      cnt          <= '0;
      quo          <= '0;
      rem          <= '0;
      dvs          <= '0;
      dz_hi        <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      dz           <= 1'b0;
    end else if (flushE) begin
      state        <= IDLE;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (startE) begin
          if (!opE[1]) begin
            hi_o         <= prod[63:32];
            lo_o         <= prod[31:0];
            result_valid <= 1'b1;
            state        <= DONE;
          end else begin
            quo   <= a_mag;
            rem   <= '0;
            dvs   <= b_mag;
            neg_q <= sgn & (srcaE[31] ^ srcbE[31]);
            neg_r <= sgn & srcaE[31];
            dz    <= (srcbE == '0);
            dz_hi <= srcaE;
            cnt   <= '0;
            state <= DIV_RUN;
          end
        end
        DIV_RUN: begin
          quo <= q_next;
          rem <= r_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(DIV_ITERS - 1)) begin
            state        <= DONE;
            result_valid <= 1'b1;
            // Divide-by-zero still runs all iterations; only the result is forced.
            if (dz) begin
              hi_o <= dz_hi;
              lo_o <= '1;
            end else begin
              hi_o <= neg_r ? -r_next : r_next;
              lo_o <= neg_q ? -q_next : q_next;
            end
          end
        end
        DONE: if (!holdE) begin
          state        <= IDLE;
          result_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: arithmetic reference model compared every cycle,
// directed literal cases, then randomized ops with holds, gaps and flushes.
module tb_muldiv_ctrl;
  logic        clk = 0, rst = 1, flushE = 0, holdE = 0, startE = 0;
  logic [1:0]  opE = 0;
  logic [31:0] srcaE = 0, srcbE = 0;
  logic        stallE, result_valid;
  logic [31:0] hi_o, lo_o;

  int checks = 0, errors = 0;
  bit chk_en = 0;

  muldiv_ctrl dut (
    .clk(clk), .rst(rst), .flushE(flushE), .holdE(holdE), .startE(startE),
    .opE(opE), .srcaE(srcaE), .srcbE(srcbE), .stallE(stallE),
    .result_valid(result_valid), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference result {HI, LO} from plain arithmetic.
  function automatic logic [63:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: begin p = sa * sb; return p; end
      2'd1: begin u = {32'd0, a} * {32'd0, b}; return u; end
      2'd2: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        q = sa / sb; r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Model: mode 0 idle, 1 dividing, 2 done.
  int          m_mode = 0, m_left = 0;
  logic [63:0] m_pend = 0;
  logic [31:0] m_hi = 0, m_lo = 0;
  logic        m_valid = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_hi = 0; m_lo = 0; m_valid = 0;
    end else if (flushE) begin
      m_mode = 0; m_valid = 0;
    end else if (m_mode == 0) begin
      if (startE) begin
        if (!opE[1]) begin
          {m_hi, m_lo} = ref_res(opE, srcaE, srcbE);
          m_valid = 1; m_mode = 2;
        end else begin
          m_pend = ref_res(opE, srcaE, srcbE);
          m_left = 32; m_mode = 1;
        end
      end
    end else if (m_mode == 1) begin
      m_left--;
      if (m_left == 0) begin
        {m_hi, m_lo} = m_pend;
        m_valid = 1; m_mode = 2;
      end
    end else if (!holdE) begin
      m_mode = 0; m_valid = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stallE", stallE, (m_mode == 0 && startE && !flushE) || m_mode == 1);
      chk("result_valid", result_valid, m_valid);
      chk("hi", hi_o, m_hi);
      chk("lo", lo_o, m_lo);
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, output int sc, output int lat);
    sc = 0; lat = 0;
    startE = 1; opE = op; srcaE = a; srcbE = b; holdE = 0;
    do begin
      @(negedge clk); if (stallE) sc++;
      @(posedge clk); #1; lat++;
    end while (!result_valid && lat < 100);
    if (lat >= 100) chk("timeout", 0, 1);
    if (hold > 0) begin
      holdE = 1;
      repeat (hold) begin @(posedge clk); #1; end
      holdE = 0;
    end
    @(posedge clk); #1;
    startE = 0;
  endtask

  task automatic flush_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int k);
    startE = 1; opE = op; srcaE = a; srcbE = b; holdE = 0;
    repeat (k) begin @(posedge clk); #1; end
    flushE = 1;
    @(posedge clk); #1;
    flushE = 0; startE = 0;
  endtask

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return $urandom_range(1, 20);
      4: return -$urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int sc, lat;
    logic [1:0] op;
    logic [31:0] a, b;

    chk("ref_multu", ref_res(2'd1, 32'hFFFFFFFF, 32'd2), 64'h00000001_FFFFFFFE);
    chk("ref_mult", ref_res(2'd0, -32'sd3, 32'd5), 64'hFFFFFFFF_FFFFFFF1);
    chk("ref_div", ref_res(2'd2, -32'sd7, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
    chk("ref_ovf", ref_res(2'd2, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);

    repeat (2) @(posedge clk);
    chk_en = 1;
    #1 rst = 0;
    @(negedge clk);
    chk("reset_out", {stallE, result_valid, hi_o, lo_o}, 66'd0);
    @(posedge clk); #1;

    run_op(2'd1, 32'hFFFFFFFF, 32'd2, 0, sc, lat);
    chk("multu_stall", sc, 1); chk("multu_lat", lat, 1);
    chk("multu_res", {hi_o, lo_o}, 64'h00000001_FFFFFFFE);
    run_op(2'd0, -32'sd3, 32'd5, 0, sc, lat);
    chk("mult_res", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFF1);
    run_op(2'd2, -32'sd7, 32'd2, 0, sc, lat);
    chk("div_stall", sc, 33); chk("div_lat", lat, 33);
    chk("div_res", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(2'd3, 32'h12345678, 32'd0, 0, sc, lat);
    chk("divz_stall", sc, 33);
    chk("divz_res", {hi_o, lo_o}, 64'h12345678_FFFFFFFF);
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 0, sc, lat);
    chk("ovf_res", {hi_o, lo_o}, 64'h00000000_80000000);

    // flush at counter=10: issue edge plus 10 run edges
    flush_op(2'd3, 32'd100, 32'd7, 11);
    chk("flush_out", {stallE, result_valid, hi_o, lo_o}, {2'b00, 64'h00000000_80000000});

    startE = 1; opE = 2'd2; srcaE = 32'd1000; srcbE = 32'd3;
    repeat (6) begin @(posedge clk); #1; end
    rst = 1; startE = 0;
    @(posedge clk); #1;
    chk("rst_mid", {stallE, result_valid, hi_o, lo_o}, 66'd0);
    rst = 0;
    @(posedge clk); #1;

    run_op(2'd1, 32'd7, 32'd9, 3, sc, lat);
    chk("hold_res", {hi_o, lo_o}, 64'd63);
    run_op(2'd3, 32'd50, 32'd7, 0, sc, lat);
    chk("b2b_stall", sc, 33);
    chk("b2b_res", {hi_o, lo_o}, 64'h00000001_00000007);

    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = pick($urandom_range(0, 8));
      b  = pick($urandom_range(0, 8));
      if ($urandom_range(0, 7) == 0)
        flush_op(op, a, b, $urandom_range(0, 34));
      else begin
        run_op(op, a, b, $urandom_range(0, 3), sc, lat);
        chk("rnd_stall", sc, op[1] ? 33 : 1);
        chk("rnd_res", {hi_o, lo_o}, ref_res(op, a, b));
      end
      repeat ($urandom_range(0, 2)) begin
        holdE = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      holdE = 0;
    end

    @(negedge clk);
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
